// File: rtl/div_sched.sv
// div_sched: round-robin scheduler that shares one iterative divider among
// NREQ requesters. A request is picked in IDLE, its operands are latched and
// the divider started, the quotient (or a timeout error) is registered and
// held until the consumer acknowledges it.
//
// Optional feature: define DIV_SCHED_ZERO_CHECK_EN to short-circuit picks
// whose divisor is zero. Such a pick still pulses gnt, never pulses
// div_start, and returns kq = all ones with kq_err set.

module div_sched #(
    parameter int N    = 16,
    parameter int NREQ = 4,
    parameter int TMO  = 40,
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*N-1:0] sbc_in,
    input  logic [NREQ*N-1:0] sc_in,
    output logic [NREQ-1:0]   gnt,
    output logic              div_start,
    output logic [N-1:0]      div_sbc,
    output logic [N-1:0]      div_sc,
    input  logic [N-1:0]      div_kq,
    input  logic              div_done,
    output logic [N-1:0]      kq,
    output logic [IDW-1:0]    kq_id,
    output logic              kq_valid,
    output logic              kq_err,
    input  logic              kq_ack
);

    localparam int CW = $clog2(TMO + 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        OUT
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  tmo_cnt;

    logic           pick_valid;
    logic [IDW-1:0] pick_idx;
    logic [N-1:0]   pick_sbc;
    logic [N-1:0]   pick_sc;
    logic [IDW-1:0] next_ptr;

`ifdef DIV_SCHED_ZERO_CHECK_EN
    logic           zero_pick;
`endif

    // Index of the requester that sits 'offset' positions after 'base',
    // wrapping modulo NREQ (NREQ need not be a power of two).
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base,
                                                 input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NREQ) begin
            sum = sum - NREQ;
        end
        return IDW'(sum);
    endfunction

    // Round-robin pick: scanning from rr_ptr, the first set req bit wins.
    // The loop runs backwards so the closest candidate overwrites the others.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[wrap_idx(rr_ptr, k)]) begin
                pick_valid = 1'b1;
                pick_idx   = wrap_idx(rr_ptr, k);
            end
        end
    end

    // Operands of the picked requester, taken straight from the packed buses.
    always_comb begin
        pick_sbc = sbc_in[int'(pick_idx)*N +: N];
        pick_sc  = sc_in[int'(pick_idx)*N +: N];
    end

    // Pointer value after the current owner, so it becomes lowest priority.
    always_comb begin
        if (kq_id == IDW'(NREQ - 1)) begin
            next_ptr = '0;
        end else begin
            next_ptr = kq_id + 1'b1;
        end
    end

    // Scheduler FSM; every output is registered here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            tmo_cnt   <= '0;
            kq        <= '0;
            kq_id     <= '0;
            kq_valid  <= 1'b0;
            kq_err    <= 1'b0;
            gnt       <= '0;
            div_start <= 1'b0;
            div_sbc   <= '0;
            div_sc    <= '0;
`ifdef DIV_SCHED_ZERO_CHECK_EN
            zero_pick <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        div_sbc <= pick_sbc;
                        div_sc  <= pick_sc;
                        kq_id   <= pick_idx;
                        gnt     <= NREQ'(1) << pick_idx;
`ifdef DIV_SCHED_ZERO_CHECK_EN
                        zero_pick <= (pick_sc == '0);
                        div_start <= (pick_sc != '0);
`else
                        div_start <= 1'b1;
`endif
                        state   <= START;
                    end
                end

                START: begin
                    gnt       <= '0;
                    div_start <= 1'b0;
                    tmo_cnt   <= '0;
`ifdef DIV_SCHED_ZERO_CHECK_EN
                    if (zero_pick) begin
                        kq       <= '1;
                        kq_err   <= 1'b1;
                        kq_valid <= 1'b1;
                        state    <= OUT;
                    end else begin
                        state    <= WAIT;
                    end
`else
                    state     <= WAIT;
`endif
                end

                WAIT: begin
                    if (div_done) begin
                        kq       <= div_kq;
                        kq_err   <= 1'b0;
                        kq_valid <= 1'b1;
                        state    <= OUT;
                    end else if (tmo_cnt == CW'(TMO - 1)) begin
                        kq       <= '1;
                        kq_err   <= 1'b1;
                        kq_valid <= 1'b1;
                        state    <= OUT;
                    end else begin
                        tmo_cnt  <= tmo_cnt + 1'b1;
                    end
                end

                OUT: begin
                    if (kq_ack) begin
                        kq_valid <= 1'b0;
                        rr_ptr   <= next_ptr;
                        state    <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/div_sched.md
DIV_SCHED -- requirements
Module: div_sched

Interface
REQ-001 Parameter N, default 16: operand and quotient width, matching the shared divider.
REQ-002 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-003 Parameter TMO, default 40: WAIT timeout in cycles, required >= N+2.
REQ-004 Port clk, input, 1: single clock; all state updates on posedge.
REQ-005 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-006 Port req, input, NREQ: per-requester request level, held until granted.
REQ-007 Port sbc_in, input, NREQ*N: dividends; requester i occupies bits [i*N +: N].
REQ-008 Port sc_in, input, NREQ*N: divisors, same packing as sbc_in.
REQ-009 Port gnt, output, NREQ: one-hot grant pulse, one cycle wide.
REQ-010 Port div_start, output, 1: start pulse to the shared divider.
REQ-011 Port div_sbc and div_sc, output, N each: latched operands driven to the divider.
REQ-012 Port div_kq and div_done, input, N and 1: divider quotient and done.
REQ-013 Port kq, output, N: registered result.
REQ-014 Port kq_id, output, log2(NREQ) (min 1): index of the owning requester.
REQ-015 Port kq_valid and kq_err, output, 1 each: result valid and error flag.
REQ-016 Port kq_ack, input, 1: consumer accepts the result.

Function
REQ-017 FSM states: IDLE, START, WAIT, OUT; encoding is free.
REQ-018 IDLE, req != 0: round-robin pick, starting at rr_ptr, of the first set bit; at that edge latch its sbc/sc into div_sbc/div_sc and its index into kq_id; go to START.
REQ-019 START: gnt[kq_id] = 1 and div_start = 1 for exactly one cycle; go to WAIT; both outputs 0 in every other state.
REQ-020 WAIT: div_done is ignored in all other states, since the divider's free-running counter re-asserts done after wrap.
REQ-021 WAIT, div_done = 1: capture div_kq into kq, clear kq_err, go to OUT.
REQ-022 Divider timing: done arrives N-1 cycles after the START cycle, so req-to-kq_valid latency is N+2 cycles for N=16.
REQ-023 WAIT timeout: a counter reaching TMO without div_done sets kq = {N{1'b1}}, kq_err = 1, go to OUT.
REQ-024 OUT: kq_valid = 1; kq, kq_id and kq_err are held stable until kq_ack.
REQ-025 OUT with kq_ack = 1: at that edge set rr_ptr = kq_id+1 mod NREQ, then go to IDLE.
REQ-026 kq_ack outside OUT is ignored.
REQ-027 The earliest next grant is 2 cycles after ack: one IDLE cycle, then START.
REQ-028 req changes during START, WAIT or OUT do not affect the operation in progress.
REQ-029 A requester whose req is still high after its grant is a new request; it is served only after the others, by round-robin.
REQ-030 Starvation bound: any held req is granted within NREQ operations.

Reset
REQ-031 rst_n low: state = IDLE, rr_ptr = 0, timeout counter = 0, kq = 0, kq_id = 0, kq_valid = 0, kq_err = 0, gnt = 0, div_start = 0, div_sbc = 0, div_sc = 0.
REQ-032 Reset mid-operation aborts it with no result; the divider is re-started by the next START.

Configuration
REQ-033 Macro DIV_SCHED_ZERO_CHECK_EN: when defined, an IDLE pick with divisor 0 skips START/WAIT and goes straight to OUT with kq = {N{1'b1}} and kq_err = 1; gnt pulses in that skipped cycle and div_start stays 0.
REQ-034 Without DIV_SCHED_ZERO_CHECK_EN, a zero divisor is sent to the divider and its quotient is returned unchecked.

Verification
REQ-035 Single request: req = 4'b0001, sbc0 = 100, sc0 = 7, kq_ack tied 1 -> gnt = 0001 one cycle, kq = 14, kq_id = 0, kq_err = 0, kq_valid N+2 cycles after req.
REQ-036 Contention: req = 4'b1111 held, operands i: sbc = 60, sc = i+1 -> grant order 0,1,2,3,0; kq = 60,30,20,15.
REQ-037 Backpressure: kq_ack held low 10 cycles in OUT -> kq/kq_id/kq_valid stable throughout, no new gnt; ack -> IDLE.
REQ-038 Timeout: div_done forced 0 -> after TMO cycles in WAIT, kq = 16'hFFFF, kq_err = 1.
REQ-039 Reset mid-WAIT: rst_n low 2 cycles -> all outputs 0 at once; a fresh req is served normally.
REQ-040 Zero divisor with DIV_SCHED_ZERO_CHECK_EN: sc = 0 -> div_start never pulses, kq = 16'hFFFF, kq_err = 1, kq_valid 2 cycles after req.
